// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the register file write port between requester A (ALU writeback) and requester B (load unit).
//          Each requester has a one-entry buffer. Grants go oldest first, with a round-robin tie break.
//          Writes to X31 are discarded.
// Latency: a handshake at edge k gives RegWrite/WriteRegister/WriteData valid from edge k+1 to edge k+2.
// Backpressure: x_ready = ~full_x | grant_x, taken from registered state only, and forced low during flush.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data  requester A write handshake
//   b_valid/b_ready/b_addr/b_data  requester B write handshake
//   flush                          synchronous drop of all buffered, ungranted writes
//   RegWrite/WriteRegister/WriteData  registered write port toward the register file
//   conflict_cnt                   saturating count of both-buffers-full edges (REGFILE_ARB_STATS_EN only)
// Optional feature macro: REGFILE_ARB_STATS_EN
module regfile_wr_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  // Buffer state
  logic              full_a;
  logic              full_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;

  // Age tag. It only matters while both buffers are full.
  //   age_eq  = both entries arrived on the same edge; rr decides
  //   older_a = A holds the older entry (meaningful when age_eq is 0)
  logic age_eq;
  logic older_a;
  logic rr;        // 0 favours A, 1 favours B

  // Combinational control
  logic pick_a;
  logic grant_a_raw;
  logic grant_b_raw;
  logic grant_a;
  logic grant_b;
  logic fill_a;
  logic fill_b;
  logic held_a;
  logic held_b;
  logic nxt_age_eq;
  logic nxt_older_a;

  always_comb begin
    pick_a      = 1'b0;
    grant_a_raw = 1'b0;
    grant_b_raw = 1'b0;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    fill_a      = 1'b0;
    fill_b      = 1'b0;
    held_a      = 1'b0;
    held_b      = 1'b0;
    nxt_age_eq  = age_eq;
    nxt_older_a = older_a;

    // The winner when both buffers are full: the older entry, or rr on equal age.
    pick_a = age_eq ? ~rr : older_a;

    // Raw grants use registered state only, so ready never depends on valid.
    grant_a_raw = full_a & (~full_b | pick_a);
    grant_b_raw = full_b & (~full_a | ~pick_a);

    // Flush beats any pending grant.
    grant_a = grant_a_raw & ~flush;
    grant_b = grant_b_raw & ~flush;

    a_ready = ~flush & (~full_a | grant_a_raw);
    b_ready = ~flush & (~full_b | grant_b_raw);

    // An accepted X31 write completes the handshake but never occupies the buffer.
    fill_a = a_valid & a_ready & (a_addr != ZERO_REG);
    fill_b = b_valid & b_ready & (b_addr != ZERO_REG);

    // An entry survives the edge when it is neither granted nor flushed.
    held_a = full_a & ~grant_a & ~flush;
    held_b = full_b & ~grant_b & ~flush;

    // A fresh entry is younger than a surviving one.
    // Two fresh entries on the same edge have equal age.
    if (fill_a && fill_b) begin
      nxt_age_eq  = 1'b1;
      nxt_older_a = 1'b0;
    end else if (fill_a && held_b) begin
      nxt_age_eq  = 1'b0;
      nxt_older_a = 1'b0;
    end else if (fill_b && held_a) begin
      nxt_age_eq  = 1'b0;
      nxt_older_a = 1'b1;
    end else if (!(held_a && held_b)) begin
      // At most one entry remains, so that entry is trivially the oldest.
      nxt_age_eq  = 1'b0;
      nxt_older_a = fill_a | held_a;
    end
  end

  // Occupancy, age and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_a  <= 1'b0;
      full_b  <= 1'b0;
      age_eq  <= 1'b0;
      older_a <= 1'b0;
      rr      <= 1'b0;
    end else begin
      full_a  <= fill_a | held_a;
      full_b  <= fill_b | held_b;
      age_eq  <= nxt_age_eq;
      older_a <= nxt_older_a;
      // rr points at the requester that lost. Flush leaves it alone.
      if (grant_a) begin
        rr <= 1'b1;
      end else if (grant_b) begin
        rr <= 1'b0;
      end
    end
  end

  // Buffer payload. A refill on the grant edge overwrites the entry that is leaving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_a <= '0;
      data_a <= '0;
      addr_b <= '0;
      data_b <= '0;
    end else begin
      if (fill_a) begin
        addr_a <= a_addr;
        data_a <= a_data;
      end
      if (fill_b) begin
        addr_b <= b_addr;
        data_b <= b_data;
      end
    end
  end

  // Registered write port. Address and data hold their values when no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= grant_a | grant_b;
      if (grant_a) begin
        WriteRegister <= addr_a;
        WriteData     <= data_a;
      end else if (grant_b) begin
        WriteRegister <= addr_b;
        WriteData     <= data_b;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  // Counts edges that start with both buffers full, including flush edges.
  // Only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= 16'd0;
    end else if (full_a && full_b && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter.
// A small register-file model captures the write port so that readback can be checked.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [4:0]  a_addr = '0;
  logic [63:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_addr = '0;
  logic [63:0] b_data = '0;
  logic        flush = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Raw storage for all 32 indices, so any write to X31 would show up here.
  logic [63:0] rf [32] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RegWrite) rf[WriteRegister] <= WriteData;
  end

  regfile_wr_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .flush(flush),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
`ifdef REGFILE_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic clear_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    flush   = 1'b0;
  endtask

  // Leaves the bench at a falling edge, with reset released and edge 0 next.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_checks++; if (WriteRegister !== 5'd0) begin n_fail++; $display("FAIL reset_wreg: got %0d want 0", WriteRegister); end
    n_checks++; if (WriteData !== 64'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WriteData); end
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got a=%b b=%b want 1/1", a_ready, b_ready); end
`ifdef REGFILE_ARB_STATS_EN
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEAD_BEEF;
    @(posedge clk); #1;  // edge 0: handshake
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_e0_regwrite: got %b want 0", RegWrite); end
    @(negedge clk);
    a_valid = 1'b0;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_ready); end
    @(posedge clk); #1;  // edge 1: issue
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_issue: got we=%b reg=%0d data=%h want 1/5/deadbeef", RegWrite, WriteRegister, WriteData); end
    @(posedge clk); #1;  // edge 2: register file captures
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_e2_regwrite: got %b want 0", RegWrite); end
    n_checks++; if (rf[5] !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_readback: got %h want deadbeef", rf[5]); end
  endtask

  task automatic test_tie();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'h22;
    @(posedge clk);      // edge 0: both fill; rr=0 favours A
    @(negedge clk);
    clear_inputs();
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL tie_ready: got a=%b b=%b want 1/0", a_ready, b_ready); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd1 || WriteData !== 64'h11) begin
      n_fail++; $display("FAIL tie_first: got we=%b reg=%0d data=%h want 1/1/11", RegWrite, WriteRegister, WriteData); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd2 || WriteData !== 64'h22) begin
      n_fail++; $display("FAIL tie_second: got we=%b reg=%0d data=%h want 1/2/22", RegWrite, WriteRegister, WriteData); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b0 || rf[1] !== 64'h11 || rf[2] !== 64'h22) begin
      n_fail++; $display("FAIL tie_readback: got we=%b r1=%h r2=%h want 0/11/22", RegWrite, rf[1], rf[2]); end
  endtask

  // rr keeps its value through a flush, so a later tie goes to B.
  task automatic test_tie_after_flush();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd14; a_data = 64'h14;
    b_valid = 1'b1; b_addr = 5'd15; b_data = 64'h15;
    @(posedge clk);      // edge 0
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;  // edge 1: A issued, rr -> 1
    n_checks++; if (WriteRegister !== 5'd14) begin n_fail++; $display("FAIL rrflush_first: got %0d want 14", WriteRegister); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;  // edge 2: B dropped
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rrflush_drop: got %b want 0", RegWrite); end
    @(negedge clk);
    flush = 1'b0;
    a_valid = 1'b1; a_addr = 5'd16; a_data = 64'h16;
    b_valid = 1'b1; b_addr = 5'd17; b_data = 64'h17;
    @(posedge clk);      // edge 3: new tie with rr=1
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd17) begin n_fail++; $display("FAIL rrflush_b_first: got we=%b reg=%0d want 1/17", RegWrite, WriteRegister); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd16) begin n_fail++; $display("FAIL rrflush_a_second: got we=%b reg=%0d want 1/16", RegWrite, WriteRegister); end
    n_checks++; if (rf[15] !== 64'd0) begin n_fail++; $display("FAIL rrflush_r15: got %h want 0", rf[15]); end
  endtask

  task automatic test_age();
    do_reset();
    b_valid = 1'b1; b_addr = 5'd3; b_data = 64'h33;
    @(posedge clk);      // edge 0: B fills
    @(negedge clk);
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 64'h44;
    @(posedge clk); #1;  // edge 1: A fills, B issues
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3) begin n_fail++; $display("FAIL age_b_first: got we=%b reg=%0d want 1/3", RegWrite, WriteRegister); end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 64'h44) begin
      n_fail++; $display("FAIL age_a_second: got we=%b reg=%0d data=%h want 1/4/44", RegWrite, WriteRegister, WriteData); end

    // A refills on its own grant edge while B is still held, so B becomes the older entry.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 64'h66;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'h77;
    @(posedge clk);      // edge 0: tie
    @(negedge clk);
    b_valid = 1'b0;
    a_addr = 5'd8; a_data = 64'h88;
    @(posedge clk); #1;  // edge 1: A issued and refilled
    n_checks++; if (WriteRegister !== 5'd6) begin n_fail++; $display("FAIL age_refill_first: got %0d want 6", WriteRegister); end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7) begin n_fail++; $display("FAIL age_held_b: got we=%b reg=%0d want 1/7", RegWrite, WriteRegister); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 64'h88) begin
      n_fail++; $display("FAIL age_new_a: got we=%b reg=%0d data=%h want 1/8/88", RegWrite, WriteRegister, WriteData); end
  endtask

  task automatic test_x31();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd31; a_data = 64'hFFFF;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x31_ready: got %b want 1", a_ready); end
    @(posedge clk); #1;  // edge 0: accepted and discarded
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x31_ready_after: got %b want 1", a_ready); end
    @(negedge clk);
    a_addr = 5'd9; a_data = 64'h99;
    @(posedge clk); #1;  // edge 1: nothing to issue
    n_checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0) begin n_fail++; $display("FAIL x31_no_issue: got we=%b reg=%0d want 0/0", RegWrite, WriteRegister); end
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9) begin n_fail++; $display("FAIL x31_follow: got we=%b reg=%0d want 1/9", RegWrite, WriteRegister); end
    @(posedge clk); #1;
    n_checks++; if (rf[31] !== 64'd0 || rf[9] !== 64'h99) begin n_fail++; $display("FAIL x31_readback: got r31=%h r9=%h want 0/99", rf[31], rf[9]); end
  endtask

  task automatic test_flush();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 64'hA0;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 64'hB0;
    @(posedge clk);      // edge 0: both full
    @(negedge clk);
    flush = 1'b1;
    a_addr = 5'd12; b_addr = 5'd13;  // these handshakes must be ignored
    #1;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got a=%b b=%b want 0/0", a_ready, b_ready); end
    @(posedge clk); #1;  // edge 1: flush
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite: got %b want 0", RegWrite); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got a=%b b=%b want 1/1", a_ready, b_ready); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b want 0", RegWrite); end
    @(posedge clk); #1;
    n_checks++; if (rf[10] !== 64'd0 || rf[11] !== 64'd0 || rf[12] !== 64'd0 || rf[13] !== 64'd0) begin
      n_fail++; $display("FAIL flush_regs: got r10=%h r11=%h r12=%h r13=%h want all 0", rf[10], rf[11], rf[12], rf[13]); end
  endtask

  // Both requesters stream for 10 edges, then reset is asserted between edges.
  task automatic test_back_to_back();
    logic [4:0]  exp_wr;
    logic [63:0] exp_wd;
    do_reset();
    a_valid = 1'b1; a_addr = 5'd20; a_data = 64'hAAAA;
    b_valid = 1'b1; b_addr = 5'd21; b_data = 64'hBBBB;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_checks++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL stream_ready[%0d]: got a=%b b=%b want %b/%b", k, a_ready, b_ready, (k % 2 == 0), (k % 2 == 1)); end
      if (k >= 1) begin
        exp_wr = (k % 2 == 1) ? 5'd20 : 5'd21;
        exp_wd = (k % 2 == 1) ? 64'hAAAA : 64'hBBBB;
        n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== exp_wr || WriteData !== exp_wd) begin
          n_fail++; $display("FAIL stream_issue[%0d]: got we=%b reg=%0d data=%h want 1/%0d/%h", k, RegWrite, WriteRegister, WriteData, exp_wr, exp_wd); end
      end
    end
`ifdef REGFILE_ARB_STATS_EN
    n_checks++; if (conflict_cnt !== 16'd9) begin n_fail++; $display("FAIL stats_cnt: got %0d want 9", conflict_cnt); end
`endif
    #2;
    rst = 1'b0;          // between edges
    #1;
    n_checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0) begin n_fail++; $display("FAIL midreset_out: got we=%b reg=%0d want 0/0", RegWrite, WriteRegister); end
`ifdef REGFILE_ARB_STATS_EN
    n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL midreset_cnt: got %0d want 0", conflict_cnt); end
`endif
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL midreset_lost1: got %b want 0", RegWrite); end
    @(posedge clk); #1;
    n_checks++; if (RegWrite !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_lost2: got we=%b a=%b b=%b want 0/1/1", RegWrite, a_ready, b_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_tie_after_flush();
    test_age();
    test_x31();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
